// File: rtl/lsu_port.sv
// Load/store initiator: one RISC-V access per request, split into two word transactions across a boundary.
// Latency 2 cycles aligned, 3 split, 1 illegal, +1 per mem_ready=0 cycle; req_ready only in IDLE, bus held while stalled.
module lsu_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic [31:0] acc_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        in_legal;
  logic [1:0]  off;
  logic [2:0]  size;
  logic [3:0]  size_mask;
  logic [31:0] wd_masked;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic        split;
  logic [31:0] word_addr;
  logic [31:0] rd_first;
  logic [31:0] rd_join;
  logic [31:0] rd_final;
  logic        finish;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    case (f3)
      3'b000:  r = {{24{v[7]}}, v[7:0]};
      3'b001:  r = {{16{v[15]}}, v[15:0]};
      3'b010:  r = v;
      3'b100:  r = {24'd0, v[7:0]};
      3'b101:  r = {16'd0, v[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept   = req_valid && req_ready;
  assign in_legal = (is_load ^ is_store)
                 && (funct3 != 3'b011) && (funct3[2:1] != 2'b11)
                 && !(is_store && funct3[2]);

  assign off = req_q.addr[1:0];

  always_comb begin
    size      = 3'd4;
    size_mask = 4'b1111;
    case (req_q.funct3[1:0])
      2'b00: begin size = 3'd1; size_mask = 4'b0001; end
      2'b01: begin size = 3'd2; size_mask = 4'b0011; end
      default: begin size = 3'd4; size_mask = 4'b1111; end
    endcase
  end

  // Lanes beyond the access size are cleared so unused write lanes stay 0.
  assign wd_masked = req_q.wdata & {{8{size_mask[3]}}, {8{size_mask[2]}},
                                    {8{size_mask[1]}}, {8{size_mask[0]}}};

  // Shift into a double-word window: low half is the first access, high half the second.
  assign be_wide   = {4'b0000, size_mask} << off;
  assign wd_wide   = {32'd0, wd_masked} << {off, 3'b000};
  assign split     = ({1'b0, off} + size) > 3'd4;
  assign word_addr = {req_q.addr[31:2], 2'b00};

  assign rd_first = mem_rdata >> {off, 3'b000};
  assign rd_join  = acc_q | (mem_rdata << {(3'd4 - {1'b0, off}), 3'b000});
  assign rd_final = (state == ACC1) ? rd_join : rd_first;
  assign finish   = mem_ready && (((state == ACC0) && !split) || (state == ACC1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = in_legal ? ACC0 : DONE;
      end
      ACC0: begin
        mem_valid = 1'b1;
        mem_we    = req_q.is_store;
        mem_addr  = word_addr;
        mem_be    = be_wide[3:0];
        mem_wdata = wd_wide[31:0];
        if (mem_ready) state_nxt = split ? ACC1 : DONE;
      end
      ACC1: begin
        mem_valid = 1'b1;
        mem_we    = req_q.is_store;
        mem_addr  = word_addr + 32'd4;
        mem_be    = be_wide[7:4];
        mem_wdata = wd_wide[63:32];
        if (mem_ready) state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= '{is_load: is_load, is_store: is_store, funct3: funct3,
                   addr: addr, wdata: wdata};
        if (!in_legal) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
      if ((state == ACC0) && mem_ready) acc_q <= rd_first;
      if (finish) begin
        err_q   <= 1'b0;
        rdata_q <= req_q.is_load ? extend(req_q.funct3, rd_final) : 32'd0;
      end
    end
  end

  assign rdata    = rdata_q;
  assign resp_err = err_q;

endmodule

// File: tb/tb_lsu_port.sv
// Bench for lsu_port: directed cases then random requests against a byte-addressed memory model.
module tb_lsu_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        resp_valid, resp_err;
  logic [31:0] rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  wmem [logic [31:0]];
  logic [31:0] obs_addr [2];
  logic [3:0]  obs_be   [2];
  logic        obs_we   [2];
  logic [31:0] obs_wd   [2];
  logic [31:0] last_rdata;
  int          last_cyc;

  always #5 clk = ~clk;

  lsu_port dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
  endfunction

  task automatic write_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) wmem[a + i] = v[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int stalls, input bit noise, input string tag);
    int          size, n_exp, n_obs, cyc, scnt, resp_cyc, exp_cyc;
    bit          legal, got, fresh;
    logic [31:0] exp_words [2];
    logic [3:0]  exp_be    [2];
    logic [31:0] exp_wd    [2];
    logic [31:0] v, ba, w;
    logic        r_err;
    logic [31:0] r_rdata;

    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (ld != st) && ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                           (ld && ((f3 == 3'b100) || (f3 == 3'b101))));
    n_exp = 0;
    v     = '0;
    for (int k = 0; k < 2; k++) begin exp_words[k] = '0; exp_be[k] = '0; exp_wd[k] = '0; end
    if (legal) begin
      for (int i = 0; i < size; i++) begin
        ba = a + i;
        w  = {ba[31:2], 2'b00};
        if (n_exp == 0 || w != exp_words[n_exp-1]) begin
          exp_words[n_exp] = w;
          n_exp++;
        end
        exp_be[n_exp-1][ba[1:0]]         = 1'b1;
        exp_wd[n_exp-1][8*ba[1:0] +: 8]  = wd[8*i +: 8];
        v = v | ({24'd0, rd_byte(ba)} << (8*i));
      end
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      if (st) v = '0;
    end
    exp_cyc = legal ? n_exp * (stalls + 1) + 1 : 1;

    chk({tag, ".ready_before"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    is_load = 1'($urandom); is_store = 1'($urandom);

    cyc = 0; got = 0; fresh = 1; scnt = 0; n_obs = 0; resp_cyc = 0;
    r_err = 1'b0; r_rdata = '0;
    while (!got && cyc < 60) begin
      cyc++;
      if (resp_valid) begin
        got = 1; resp_cyc = cyc; r_err = resp_err; r_rdata = rdata;
        req_valid = 1'b0;
        chk({tag, ".no_bus_at_resp"}, {31'd0, mem_valid}, 32'd0);
      end else if (mem_valid) begin
        if (fresh) begin
          if (n_obs < 2) begin
            obs_addr[n_obs] = mem_addr; obs_be[n_obs] = mem_be;
            obs_we[n_obs] = mem_we; obs_wd[n_obs] = mem_wdata;
          end
          n_obs++;
          fresh = 0;
        end else if (n_obs <= 2) begin
          chk({tag, ".hold_addr"}, mem_addr, obs_addr[n_obs-1]);
          chk({tag, ".hold_be"}, {28'd0, mem_be}, {28'd0, obs_be[n_obs-1]});
          chk({tag, ".hold_wdata"}, mem_wdata, obs_wd[n_obs-1]);
        end
        mem_rdata = rd_word(mem_addr);
        if (scnt < stalls) begin
          mem_ready = 1'b0; scnt++;
        end else begin
          mem_ready = 1'b1; scnt = 0; fresh = 1;
          if (mem_we)
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) wmem[mem_addr + i] = mem_wdata[8*i +: 8];
        end
      end else begin
        mem_ready = 1'b0;
      end
      if (noise && !got) begin
        req_valid = 1'($urandom); addr = $urandom; funct3 = 3'($urandom);
      end
      if (!got) begin @(posedge clk); #1; end
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    last_rdata = r_rdata;
    last_cyc   = resp_cyc;

    chk({tag, ".resp_seen"}, {31'd0, got}, 32'd1);
    chk({tag, ".latency"}, resp_cyc, exp_cyc);
    chk({tag, ".err"}, {31'd0, r_err}, {31'd0, !legal});
    chk({tag, ".rdata"}, r_rdata, v);
    chk({tag, ".n_access"}, n_obs, n_exp);
    for (int k = 0; k < n_exp && k < n_obs; k++) begin
      chk($sformatf("%s.addr%0d", tag, k), obs_addr[k], exp_words[k]);
      chk($sformatf("%s.be%0d", tag, k), {28'd0, obs_be[k]}, {28'd0, exp_be[k]});
      chk($sformatf("%s.we%0d", tag, k), {31'd0, obs_we[k]}, {31'd0, st});
      if (st) chk($sformatf("%s.wdata%0d", tag, k), obs_wd[k], exp_wd[k]);
    end
    if (legal && st)
      for (int i = 0; i < size; i++)
        chk($sformatf("%s.mem%0d", tag, i), {24'd0, rd_byte(a + i)}, {24'd0, wd[8*i +: 8]});

    @(posedge clk); #1;
    chk({tag, ".pulse_one_cycle"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".rdata_hold"}, rdata, r_rdata);
  endtask

  initial begin
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;

    reset = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = '0; addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst.mem_bus", {mem_addr[27:0], mem_be} | mem_wdata | {31'd0, mem_we}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    write_word(32'h100, 32'hDEADBEEF);
    do_req(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, "lw_aligned");
    chk("lw_aligned.value", last_rdata, 32'hDEADBEEF);
    chk("lw_aligned.be", {28'd0, obs_be[0]}, 32'hF);

    write_word(32'h100, 32'h0080FF00);
    do_req(1, 0, 3'b000, 32'h102, 32'h0, 0, 0, "lb");
    chk("lb.value", last_rdata, 32'hFFFFFF80);
    do_req(1, 0, 3'b100, 32'h102, 32'h0, 0, 0, "lbu");
    chk("lbu.value", last_rdata, 32'h00000080);
    chk("lbu.be", {28'd0, obs_be[0]}, 32'h4);

    write_word(32'h100, 32'hAB000000);
    write_word(32'h104, 32'h000000CD);
    do_req(1, 0, 3'b101, 32'h103, 32'h0, 0, 0, "lhu_split");
    chk("lhu_split.value", last_rdata, 32'h0000CDAB);
    chk("lhu_split.cycle", last_cyc, 3);
    chk("lhu_split.addr1", obs_addr[1], 32'h104);

    do_req(0, 1, 3'b010, 32'h201, 32'h11223344, 2, 0, "sw_split");
    chk("sw_split.wd0", obs_wd[0], 32'h22334400);
    chk("sw_split.be0", {28'd0, obs_be[0]}, 32'hE);
    chk("sw_split.wd1", obs_wd[1], 32'h00000011);
    chk("sw_split.be1", {28'd0, obs_be[1]}, 32'h1);

    do_req(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, "illegal_f3");
    do_req(0, 1, 3'b100, 32'h100, 32'h5, 0, 0, "illegal_sbu");
    do_req(1, 1, 3'b010, 32'h100, 32'h0, 0, 0, "illegal_both");

    do_req(1, 0, 3'b010, 32'hFFFFFFFE, 32'h0, 1, 0, "lw_wrap");
    chk("lw_wrap.addr1", obs_addr[1], 32'h00000000);

    for (int n = 0; n < 250; n++) begin
      r  = $urandom_range(0, 9);
      ld = 1'($urandom);
      st = !ld;
      if (r == 0) begin ld = 1'b0; st = 1'b0; end
      if (r == 1) begin ld = 1'b1; st = 1'b1; end
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                       : 32'h1000 + $urandom_range(0, 63);
      do_req(ld, st, f3, a, $urandom, $urandom_range(0, 2), 1, $sformatf("rnd%0d", n));
    end

    // Reset while the first access is stalled, with a handshake in the reset cycle.
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_rst.in_acc0", {31'd0, mem_valid}, 32'd1);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    chk("mid_rst.mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("mid_rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst.rdata", rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst.no_resp", {31'd0, resp_valid | mem_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
